// File: rtl/wsg_pkg.sv
// Shared types and constants for the WSG voice sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wsg_pkg;

  localparam int NUM_VOICES = 3;
  localparam int ACC_W      = 20;
  localparam int ROM_ADDR_W = 8;
  localparam int SAMPLE_W   = 10;
  localparam int WAVE_W     = 3;
  localparam int VOL_W      = 4;
  localparam int NIB_W      = 4;
  localparam int IDX_W      = ROM_ADDR_W - WAVE_W;  // 5-bit waveform step index
  localparam int PROD_W     = NIB_W + VOL_W;        // nibble * volume, max 225

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, MAC, DONE} wsg_state_t;

  typedef logic [ACC_W-1:0] wsg_acc_t;

  // Waveform step index taken from the top bits of a phase accumulator.
  function automatic logic [IDX_W-1:0] rom_index(input wsg_acc_t acc);
    return acc[ACC_W-1 -: IDX_W];
  endfunction

endpackage

// File: rtl/wsg_tick_div.sv
// Free-running sample-rate divider producing a 1-clk tick strobe.
// Latency: tick asserts while the count sits at TICK_DIV-1, then the count wraps to 0.
// Backpressure: none; the divider never stalls.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   tick     : 1-clk strobe once every TICK_DIV clocks
module wsg_tick_div #(
  parameter int TICK_DIV = 1042
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wsg_voice_sequencer.sv
// Time-multiplexes one sound-ROM port and one 4x4 multiplier over three WSG voices, emitting a 10-bit mix per tick.
// Latency: 11 clks from tick to sample_valid (3 voices x ADDR/WAIT/MAC, then DONE).
// Backpressure: none downstream; a tick arriving while busy is dropped and flagged on overrun.
//
// Optional feature macro: WSG_VOICE_MUTE_EN adds mute_mask (bit v mutes voice v+1 in the mix).
//
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   freq_1/freq_2/freq_3 : phase increments (voices 2/3 are shifted left by 4)
//   wave_1..3, vol_1..3  : waveform select and volume per voice
//   mute_mask            : (WSG_VOICE_MUTE_EN only) per-voice mute, sampled in MAC
//   rom_addr, rom_data   : sound ROM port, data returns 1 clk after the address
//   sample_out           : mixed sample, held between updates
//   sample_valid         : 1-clk pulse when sample_out updates
//   busy                 : high while a sequence is in progress
//   overrun              : 1-clk pulse when a tick is dropped because busy
module wsg_voice_sequencer
  import wsg_pkg::*;
#(
  parameter int TICK_DIV = 1042
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ACC_W-1:0]      freq_1,
  input  logic [15:0]           freq_2,
  input  logic [15:0]           freq_3,
  input  logic [WAVE_W-1:0]     wave_1,
  input  logic [WAVE_W-1:0]     wave_2,
  input  logic [WAVE_W-1:0]     wave_3,
  input  logic [VOL_W-1:0]      vol_1,
  input  logic [VOL_W-1:0]      vol_2,
  input  logic [VOL_W-1:0]      vol_3,
`ifdef WSG_VOICE_MUTE_EN
  input  logic [NUM_VOICES-1:0] mute_mask,
`endif
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [NIB_W-1:0]      rom_data,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  logic                tick;
  wsg_state_t          state;
  logic [1:0]          v;
  wsg_acc_t            acc [NUM_VOICES];
  logic [SAMPLE_W-1:0] mix;

  // Current-voice selections; inputs are sampled in the cycle they are used.
  logic [WAVE_W-1:0]   sel_wave;
  logic [VOL_W-1:0]    sel_vol;
  wsg_acc_t            sel_acc;
  wsg_acc_t            sel_inc;
  wsg_acc_t            acc_nxt;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   contrib;

  wsg_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    sel_wave = '0;
    sel_vol  = '0;
    sel_acc  = '0;
    sel_inc  = '0;
    case (v)
      2'd0: begin
        sel_wave = wave_1;
        sel_vol  = vol_1;
        sel_acc  = acc[0];
        sel_inc  = freq_1;
      end
      2'd1: begin
        sel_wave = wave_2;
        sel_vol  = vol_2;
        sel_acc  = acc[1];
        sel_inc  = {freq_2, 4'h0};
      end
      2'd2: begin
        sel_wave = wave_3;
        sel_vol  = vol_3;
        sel_acc  = acc[2];
        sel_inc  = {freq_3, 4'h0};
      end
      default: ;
    endcase
  end

  // Single shared phase adder; wraps silently mod 2^ACC_W.
  assign acc_nxt = sel_acc + sel_inc;

  // Single shared 4x4 multiplier.
  assign prod = {{VOL_W{1'b0}}, rom_data} * {{NIB_W{1'b0}}, sel_vol};

`ifdef WSG_VOICE_MUTE_EN
  logic sel_mute;
  assign sel_mute = |(mute_mask & (NUM_VOICES'(1) << v));
  assign contrib  = sel_mute ? '0 : prod;
`else
  assign contrib  = prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      v            <= '0;
      mix          <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      // The divider keeps running; a tick seen outside IDLE is simply lost.
      overrun      <= tick && (state != IDLE);
      case (state)
        IDLE: begin
          mix <= '0;
          v   <= '0;
          if (tick) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          // Address uses the pre-increment phase.
          rom_addr <= {sel_wave, rom_index(sel_acc)};
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (v == 2'(i)) begin
              acc[i] <= acc_nxt;
            end
          end
          state <= WAIT;
        end
        WAIT: begin
          state <= MAC;
        end
        MAC: begin
          // 3 x 225 = 675 fits in 10 bits, so no saturation is needed.
          mix <= mix + SAMPLE_W'(contrib);
          if (v == 2'(NUM_VOICES - 1)) begin
            state <= DONE;
          end else begin
            v     <= v + 2'd1;
            state <= ADDR;
          end
        end
        DONE: begin
          sample_out   <= mix;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wsg_voice_sequencer.sv
// Scoreboard bench for wsg_voice_sequencer: directed vectors push expected samples and ROM addresses,
// independent monitors pop and compare when the DUT presents them.
module tb_wsg_voice_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] freq_1;
  logic [15:0] freq_2, freq_3;
  logic [2:0]  wave_1, wave_2, wave_3;
  logic [3:0]  vol_1, vol_2, vol_3;
`ifdef WSG_VOICE_MUTE_EN
  logic [2:0]  mute_mask;
`endif
  logic [7:0]  rom_addr;
  logic [3:0]  rom_data;
  logic [9:0]  sample_out;
  logic        sample_valid, busy, overrun;
  logic        rom_force_f;

  int errors = 0;
  int checks = 0;
  int exp_samp[$];
  int exp_addr[$];
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  wsg_voice_sequencer #(.TICK_DIV(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .freq_1       (freq_1),
    .freq_2       (freq_2),
    .freq_3       (freq_3),
    .wave_1       (wave_1),
    .wave_2       (wave_2),
    .wave_3       (wave_3),
    .vol_1        (vol_1),
    .vol_2        (vol_2),
    .vol_3        (vol_3),
`ifdef WSG_VOICE_MUTE_EN
    .mute_mask    (mute_mask),
`endif
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Registered sound ROM: nibble = addr[3:0], or forced to F.
  always @(posedge clk) rom_data <= rom_force_f ? 4'hF : rom_addr[3:0];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Sample monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        if (exp_samp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample_valid: got pulse with sample_out=%0d, expected no pulse", sample_out);
        end else begin
          check("sample_out", int'(sample_out), exp_samp.pop_front());
        end
      end
    end
  end

  // Address monitor: busy rises in the first ADDR cycle; voice addresses appear 1, 4 and 7 clks later.
  initial begin
    int k;
    bit bprev;
    k = 0;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && !bprev) k = 0;
      else if (busy === 1'b1) k++;
      if (busy === 1'b1 && (k == 1 || k == 4 || k == 7) && exp_addr.size() > 0)
        check("rom_addr", int'(rom_addr), exp_addr.pop_front());
      bprev = (busy === 1'b1);
    end
  end

  // Overrun pulse counter.
  initial begin
    forever begin
      @(negedge clk);
      if (overrun === 1'b1) ovr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_seq(input int s, input int a0, input int a1, input int a2);
    exp_samp.push_back(s);
    exp_addr.push_back(a0);
    exp_addr.push_back(a1);
    exp_addr.push_back(a2);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (sample_valid === 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no sample_valid in 200 clks, expected one", name);
    end
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (busy === 1'b1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_busy_timeout: got busy=0 for 200 clks, expected busy=1", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_voices(input logic [19:0] f1, input logic [15:0] f2, input logic [15:0] f3,
                            input logic [2:0] w1, input logic [2:0] w2, input logic [2:0] w3,
                            input logic [3:0] v1, input logic [3:0] v2, input logic [3:0] v3);
    freq_1 = f1; freq_2 = f2; freq_3 = f3;
    wave_1 = w1; wave_2 = w2; wave_3 = w3;
    vol_1  = v1; vol_2  = v2; vol_3  = v3;
  endtask

  initial begin
    int n;
    int ovr_base;
    bit seen;
    rst = 1'b1;
    rom_force_f = 1'b0;
`ifdef WSG_VOICE_MUTE_EN
    mute_mask = 3'b000;
`endif
    // Voice 1 sweeps wave 2 one step per tick; voices 2/3 silent.
    set_voices(20'h08000, 16'h0, 16'h0, 3'd2, 3'd0, 3'd0, 4'd15, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("reset_sample_out", int'(sample_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_sample_valid", int'(sample_valid), 0);
    check("reset_overrun", int'(overrun), 0);

    // Phase stepping, address format and scaling.
    push_seq(0,  8'h40, 8'h00, 8'h00);
    push_seq(15, 8'h41, 8'h00, 8'h00);
    push_seq(30, 8'h42, 8'h00, 8'h00);
    rst = 1'b0;
    wait_valid("t2_tick1");
    wait_valid("t2_tick2");
    wait_valid("t2_tick3");

    // Reset in the middle of a sequence: no output, state cleared, clean restart.
    wait_busy("t1");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_sample_out", int'(sample_out), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_rom_addr", int'(rom_addr), 0);
    repeat (2) @(negedge clk);
    push_seq(0, 8'h40, 8'h00, 8'h00);
    rst = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = (sample_valid === 1'b1);
    end
    // Tick after 31 clks, then 11 clks to sample_valid.
    check("release_to_first_valid_clks", n, 42);

    // Full-scale mix and voice order.
    rom_force_f = 1'b1;
    set_voices(20'h0, 16'h0, 16'h0, 3'd1, 3'd2, 3'd3, 4'd15, 4'd15, 4'd15);
    do_reset();
    push_seq(675, 8'h20, 8'h40, 8'h60);
    wait_valid("t3");

    // Accumulator wrap: 0 -> FFFFF -> FFFFE.
    rom_force_f = 1'b0;
    set_voices(20'hFFFFF, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 4'd1, 4'd0, 4'd0);
    do_reset();
    push_seq(0,  8'h00, 8'h00, 8'h00);
    push_seq(15, 8'h1F, 8'h00, 8'h00);
    push_seq(15, 8'h1F, 8'h00, 8'h00);
    wait_valid("t4_tick1");
    wait_valid("t4_tick2");
    wait_valid("t4_tick3");

    // Extra tick while busy is dropped and flagged once.
    set_voices(20'h08000, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 4'd5, 4'd0, 4'd0);
    do_reset();
    push_seq(0, 8'h00, 8'h00, 8'h00);
    wait_busy("t5");
    repeat (3) @(negedge clk);
    ovr_base = ovr_cnt;
    force dut.tick = 1'b1;
    @(negedge clk);
    release dut.tick;
    wait_valid("t5_tick1");
    push_seq(5, 8'h01, 8'h00, 8'h00);
    wait_valid("t5_tick2");
    check("t5_overrun_pulses", ovr_cnt - ovr_base, 1);

`ifdef WSG_VOICE_MUTE_EN
    // Voice 2 muted: mix excludes it, but its phase still advances.
    rom_force_f = 1'b1;
    mute_mask = 3'b010;
    set_voices(20'h0, 16'h0800, 16'h0, 3'd0, 3'd0, 3'd0, 4'd15, 4'd15, 4'd15);
    do_reset();
    push_seq(450, 8'h00, 8'h00, 8'h00);
    push_seq(450, 8'h00, 8'h01, 8'h00);
    wait_valid("t6_tick1");
    wait_valid("t6_tick2");
    mute_mask = 3'b000;
`endif

    repeat (5) @(negedge clk);
    check("samples_outstanding", exp_samp.size(), 0);
    check("addrs_outstanding", exp_addr.size(), 0);
    check("total_overrun_pulses", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
